lvds_capture_packer: RTL and testbench

- Next-generation LVDS capture stage for the logic analyzer.
- Sits directly after the differential input buffers. Clock, data lanes and strobe are already single-ended and synchronous to Clock.
- Registers the lanes and qualifies samples by a selectable strobe mode.
- Packs PACK consecutive samples into one wide word and buffers the words in a FIFO with a valid/ready output handshake. It also reports overflow and a running sample count.

---
 rtl/lvds_capture_packer.sv | 163 ++++++++++++++++
 tb/tb_lvds_capture_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lvds_capture_packer.sv
// LVDS capture stage: registers the lanes, qualifies samples by strobe mode,
// packs PACK samples per word and queues the words in a show-ahead FIFO.
module lvds_capture_packer #(
    parameter int LVDS_LEN   = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic                            Clock,
    input  logic                            Reset_n,
    input  logic                            Enable,
    input  logic                            Clear,
    input  logic [1:0]                      Mode,
    input  logic [LVDS_LEN-1:0]             DataIN,
    input  logic                            StrobIN,
    output logic [LVDS_LEN*PACK-1:0]        DataOUT,
    output logic                            ValidOUT,
    input  logic                            ReadyIN,
    output logic                            Overflow,
    output logic [$clog2(FIFO_DEPTH):0]     Level,
    output logic [CNT_W-1:0]                SampleCnt
);

    localparam int WORD_W = LVDS_LEN * PACK;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(PACK - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [AW:0]      LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]      LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]      LEVEL_ZERO = (AW + 1)'(0);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [LVDS_LEN-1:0] d_r_q,      d_r_d;
    logic                s_r_q,      s_r_d;
    logic                s_prev_q,   s_prev_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [WORD_W-1:0]   pack_q,     pack_d;
    logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [AW:0]         level_q,    level_d;
    logic [WORD_W-1:0]   data_out_q, data_out_d;
    logic                valid_q,    valid_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;

    logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];

    logic                mode_hit_s;
    logic                qual_s;
    logic [WORD_W-1:0]   word_s;
    logic                push_req_s;
    logic                push_ok_s;
    logic                pop_s;

    // Qualification, packing and FIFO next-state logic.
    always_comb begin
        d_r_d    = DataIN;
        s_r_d    = StrobIN;
        s_prev_d = s_r_q;

        case (Mode)
            2'd1:    mode_hit_s = 1'b1;
            2'd2:    mode_hit_s = s_r_q & ~s_prev_q;
            default: mode_hit_s = s_r_q;
        endcase
        qual_s = Enable & mode_hit_s;

        // The word as it stands with the current sample dropped into its slot;
        // when idx is the last slot this is the completed word.
        word_s = pack_q;
        word_s[idx_q*LVDS_LEN +: LVDS_LEN] = d_r_q;

        push_req_s = qual_s & (idx_q == IDX_LAST);
        pop_s      = valid_q & ReadyIN;
        push_ok_s  = push_req_s & ((level_q != LEVEL_FULL) | pop_s);

        if (!Enable) begin
            idx_d = '0;
        end else if (qual_s) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end else begin
            idx_d = idx_q;
        end

        if (qual_s) begin
            pack_d = word_s;
            cnt_d  = cnt_q + CNT_ONE;
        end else begin
            pack_d = pack_q;
            cnt_d  = cnt_q;
        end

        wr_ptr_d = push_ok_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_s     ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase

        // Head after this edge: hold when empty, bypass a word landing in an
        // empty FIFO, otherwise read the entry the read pointer will point at.
        if (level_d == LEVEL_ZERO) begin
            data_out_d = data_out_q;
        end else if (push_ok_s && (level_d == LEVEL_ONE)) begin
            data_out_d = word_s;
        end else begin
            data_out_d = mem_q[rd_ptr_d];
        end

        valid_d    = (level_d != LEVEL_ZERO);
        overflow_d = overflow_q | (push_req_s & ~push_ok_s);
    end

    // State registers; reset and Clear return everything to the idle state.
    always_ff @(posedge Clock) begin
        if (!Reset_n || Clear) begin
            d_r_q      <= '0;
            s_r_q      <= 1'b0;
            s_prev_q   <= 1'b0;
            idx_q      <= '0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            d_r_q      <= d_r_d;
            s_r_q      <= s_r_d;
            s_prev_q   <= s_prev_d;
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge Clock) begin
        if (Reset_n && !Clear && push_ok_s) begin
            mem_q[wr_ptr_q] <= word_s;
        end
    end

    assign DataOUT   = data_out_q;
    assign ValidOUT  = valid_q;
    assign Overflow  = overflow_q;
    assign Level     = level_q;
    assign SampleCnt = cnt_q;

endmodule

// File: tb/tb_lvds_capture_packer.sv
// Scoreboard bench for lvds_capture_packer: directed stimulus queues expected
// words, a negedge monitor pops and compares every accepted output word.
module tb_lvds_capture_packer;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Enable;
    logic        Clear;
    logic [1:0]  Mode;
    logic [7:0]  DataIN;
    logic        StrobIN;
    logic [31:0] DataOUT;
    logic        ValidOUT;
    logic        ReadyIN;
    logic        Overflow;
    logic [4:0]  Level;
    logic [31:0] SampleCnt;

    logic [31:0] exp_q [$];
    int vectors    = 0;
    int miscompares = 0;

    lvds_capture_packer #(
        .LVDS_LEN(8), .PACK(4), .FIFO_DEPTH(16), .CNT_W(32)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Clear(Clear),
        .Mode(Mode), .DataIN(DataIN), .StrobIN(StrobIN), .DataOUT(DataOUT),
        .ValidOUT(ValidOUT), .ReadyIN(ReadyIN), .Overflow(Overflow),
        .Level(Level), .SampleCnt(SampleCnt)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic st, input logic [7:0] d);
        Enable  = en;
        StrobIN = st;
        DataIN  = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_clear();
        Clear = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        Clear = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int j);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*j);
        b1 = 8'(4*j + 1);
        b2 = 8'(4*j + 2);
        b3 = 8'(4*j + 3);
        return {b3, b2, b1, b0};
    endfunction

    // Monitor: every accepted word must match the oldest expected word.
    always @(negedge Clock) begin
        if (Reset_n === 1'b1 && Clear === 1'b0 && ValidOUT === 1'b1 && ReadyIN === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", DataOUT);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (DataOUT !== e) begin
                    miscompares++;
                    $display("FAIL word: got 0x%0h, expected 0x%0h", DataOUT, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; Enable = 1'b0; Clear = 1'b0; Mode = 2'd1;
        DataIN = 8'h00; StrobIN = 1'b0; ReadyIN = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        check("rst_dataout", DataOUT, 64'h0);
        check("rst_valid", ValidOUT, 64'h0);

        // Idle with Enable low: nothing is qualified.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
        check("idle_valid", ValidOUT, 64'h0);
        check("idle_level", Level, 64'h0);
        check("idle_cnt", SampleCnt, 64'h0);
        check("idle_ovf", Overflow, 64'h0);

        // Packing in Mode 1 with latency check.
        do_clear();
        exp_q.push_back(32'h44332211);
        cyc(1'b0, 1'b0, 8'h11);
        cyc(1'b1, 1'b0, 8'h22);
        cyc(1'b1, 1'b0, 8'h33);
        cyc(1'b1, 1'b0, 8'h44);
        check("lat_valid_early", ValidOUT, 64'h0);
        cyc(1'b1, 1'b0, 8'h00);
        check("lat_valid", ValidOUT, 64'h1);
        check("lat_data", DataOUT, 64'h44332211);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("pack_cnt", SampleCnt, 64'd4);
        check("pack_level", Level, 64'h0);

        // Mode 2: only strobe rising edges qualify (samples 1 and 5).
        do_clear();
        Mode = 2'd2;
        cyc(1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b1, 8'd1);
        cyc(1'b1, 1'b1, 8'd2);
        cyc(1'b1, 1'b1, 8'd3);
        cyc(1'b1, 1'b0, 8'd4);
        cyc(1'b1, 1'b1, 8'd5);
        cyc(1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0);
        check("edge_cnt", SampleCnt, 64'd2);
        check("edge_level", Level, 64'h0);

        // Mode 0: strobe-high samples C0,C2,C3,C5 form one word.
        do_clear();
        Mode = 2'd0;
        exp_q.push_back(32'hC5C3C2C0);
        cyc(1'b0, 1'b1, 8'hC0);
        cyc(1'b1, 1'b0, 8'hC1);
        cyc(1'b1, 1'b1, 8'hC2);
        cyc(1'b1, 1'b1, 8'hC3);
        cyc(1'b1, 1'b0, 8'hC4);
        cyc(1'b1, 1'b1, 8'hC5);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("strobe_cnt", SampleCnt, 64'd4);
        check("strobe_left", exp_q.size(), 64'd0);

        // Overflow: 68 samples into a stalled FIFO.
        do_clear();
        Mode = 2'd1;
        ReadyIN = 1'b0;
        for (int w = 0; w < 16; w++) exp_q.push_back(word_of(w));
        cyc(1'b0, 1'b0, 8'd0);
        for (int i = 1; i < 68; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0);
        check("ovf_level", Level, 64'd16);
        check("ovf_flag", Overflow, 64'h1);
        check("ovf_cnt", SampleCnt, 64'd68);
        check("ovf_head", DataOUT, {32'h0, word_of(0)});
        ReadyIN = 1'b1;
        repeat (20) cyc(1'b0, 1'b0, 8'd0);
        check("ovf_drained", Level, 64'h0);
        check("ovf_valid", ValidOUT, 64'h0);
        check("ovf_hold", DataOUT, {32'h0, word_of(15)});
        check("ovf_left", exp_q.size(), 64'd0);
        check("ovf_sticky", Overflow, 64'h1);
        ReadyIN = 1'b0;
        do_clear();
        check("clr_ovf", Overflow, 64'h0);
        check("clr_level", Level, 64'h0);
        check("clr_cnt", SampleCnt, 64'h0);
        check("clr_data", DataOUT, 64'h0);

        // Full FIFO with push and pop on the same edge.
        for (int w = 0; w < 17; w++) exp_q.push_back(word_of(w));
        cyc(1'b0, 1'b0, 8'd0);
        for (int i = 1; i < 68; i++) cyc(1'b1, 1'b0, 8'(i));
        check("full_level", Level, 64'd16);
        ReadyIN = 1'b1;
        cyc(1'b1, 1'b0, 8'd0);
        ReadyIN = 1'b0;
        check("pp_level", Level, 64'd16);
        check("pp_ovf", Overflow, 64'h0);
        cyc(1'b0, 1'b0, 8'd0);
        ReadyIN = 1'b1;
        repeat (20) cyc(1'b0, 1'b0, 8'd0);
        check("pp_left", exp_q.size(), 64'd0);
        check("pp_drained", Level, 64'h0);

        // Enable abort discards a partial word.
        do_clear();
        exp_q.push_back(32'hA3A2A1A0);
        cyc(1'b0, 1'b0, 8'hB0);
        cyc(1'b1, 1'b0, 8'hB1);
        cyc(1'b1, 1'b0, 8'h5A);
        cyc(1'b0, 1'b0, 8'hA0);
        cyc(1'b1, 1'b0, 8'hA1);
        cyc(1'b1, 1'b0, 8'hA2);
        cyc(1'b1, 1'b0, 8'hA3);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        check("abort_cnt", SampleCnt, 64'd6);
        check("abort_level", Level, 64'h0);

        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        check("leftover_words", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
